serial_add_ctrl: RTL and testbench

Controller and datapath for the serial adder. Adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full adder and a carry flip-flop. It is the stage directly downstream of the bit counter: it drives the counter's enable and clear, and consumes the counter's terminal-count flag to end the operation. It then presents the sum and carry-out with a one-cycle done strobe.

---
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with its own sequencing FSM. It adds two WIDTH-bit operands LSB-first,
// one bit per clock, and hands counting off to an external bit counter via en_count/cnt_clr/compare.
//
// state | meaning
// IDLE  | waiting for start; counter held clear
// LOAD  | capture operands and carry-in; counter held clear
// SHIFT | one full-adder bit per cycle until the counter flags terminal count
// DONE  | one-cycle done strobe; result held
// ERR   | counter never flagged; raise sticky err
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             compare,
    output logic             en_count,
    output logic             cnt_clr,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry;
    logic [CW-1:0]    shadow;
    logic             bit_s, bit_c;

    assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        en_count  = 1'b0;
        cnt_clr   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                cnt_clr   = 1'b1;
                busy      = 1'b1;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                // The counter's flag wins over the shadow count, so an early flag ends the add.
                if (compare)                     state_nxt = S_DONE;
                else if (shadow < CW'(WIDTH))    en_count  = 1'b1;
                else                             state_nxt = S_ERR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            shadow <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    a_sh   <= a;
                    b_sh   <= b;
                    carry  <= cin;
                    shadow <= '0;
                    err    <= 1'b0;
                    sum    <= '0;
                end
                S_SHIFT: begin
                    if (en_count) begin
                        carry  <= bit_c;
                        sum    <= {bit_s, sum[WIDTH-1:1]};
                        a_sh   <= a_sh >> 1;
                        b_sh   <= b_sh >> 1;
                        shadow <= shadow + CW'(1);
                    end else if (compare) begin
                        cout <= carry;
                    end
                end
                S_ERR:   err <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: behavioural bit counter plus an arithmetic reference (a+b+cin).
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       compare;
    logic       en_count, cnt_clr, cout, busy, done, err;
    logic [7:0] sum;

    int checks = 0;
    int errors = 0;
    int lat, en_n, busy_n, done_n;

    logic       stub_mode = 1'b0;
    logic [3:0] cnt = '0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .compare(compare), .en_count(en_count), .cnt_clr(cnt_clr),
        .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // External bit counter; stub_mode models a counter that never reaches terminal count.
    always @(posedge clk) begin
        if (cnt_clr)       cnt <= '0;
        else if (en_count) cnt <= cnt + 4'd1;
    end
    assign compare = (cnt == 4'd8) && !stub_mode;

    // Start one add from IDLE and observe 14 edges; optionally re-pulse start at edge index repulse_at.
    task automatic do_add(input logic [7:0] ta, input logic [7:0] tbv, input logic tc, input int repulse_at);
        a = ta; b = tbv; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; en_n = 0; busy_n = 0; done_n = 0;
        for (int k = 1; k <= 14; k++) begin
            en_n   += int'(en_count);
            busy_n += int'(busy);
            if (k == repulse_at) begin
                start = 1'b1; a = ~ta; b = ~tbv;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                done_n++;
                if (lat < 0) lat = k;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({sum, cout, busy, done, err, en_count, cnt_clr} !== {8'h00, 6'b000001}) begin
            errors++;
            $display("FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b err=%b en=%b clr=%b", sum, cout, busy, done, err, en_count, cnt_clr);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, cnt_clr} !== 3'b001) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b clr=%b want 0 0 1", busy, done, cnt_clr);
        end
    endtask

    task automatic test_basic();
        do_add(8'h35, 8'h4A, 1'b0, 0);
        checks++;
        if (lat !== WIDTH + 2) begin errors++; $display("FAIL basic_latency: done seen after edge %0d, want %0d", lat, WIDTH + 2); end
        checks++;
        if ({cout, sum} !== 9'h07F) begin errors++; $display("FAIL basic_sum: got cout=%b sum=%h want 0 7f", cout, sum); end
        checks++;
        if (en_n !== WIDTH) begin errors++; $display("FAIL basic_en_count: got %0d cycles want %0d", en_n, WIDTH); end
        checks++;
        if (busy_n !== WIDTH + 2) begin errors++; $display("FAIL basic_busy: got %0d cycles want %0d", busy_n, WIDTH + 2); end
        checks++;
        if (done_n !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_n); end
    endtask

    task automatic test_corners();
        do_add(8'hFF, 8'h01, 1'b0, 0);
        checks++;
        if ({cout, sum} !== 9'h100) begin errors++; $display("FAIL corner_ff_01: got cout=%b sum=%h want 1 00", cout, sum); end
        do_add(8'hFF, 8'hFF, 1'b1, 0);
        checks++;
        if ({cout, sum} !== 9'h1FF) begin errors++; $display("FAIL corner_ff_ff_c: got cout=%b sum=%h want 1 ff", cout, sum); end
    endtask

    task automatic test_random();
        logic [7:0] ta, tbv;
        logic       tc;
        logic [8:0] exp_v;
        for (int i = 0; i < 20; i++) begin
            ta = 8'($urandom); tbv = 8'($urandom); tc = 1'($urandom);
            exp_v = 9'(ta) + 9'(tbv) + 9'(tc);
            do_add(ta, tbv, tc, 0);
            checks++;
            if ({cout, sum} !== exp_v || done_n !== 1 || en_n !== WIDTH) begin
                errors++;
                $display("FAIL random_add %h+%h+%b: got %b_%h done=%0d en=%0d want %h done=1 en=8", ta, tbv, tc, cout, sum, done_n, en_n, exp_v);
            end
        end
    endtask

    task automatic test_ignore_start();
        do_add(8'h5A, 8'h3C, 1'b1, 4);
        checks++;
        if ({cout, sum} !== 9'h097) begin errors++; $display("FAIL ignore_start_sum: got cout=%b sum=%h want 0 97", cout, sum); end
        checks++;
        if (done_n !== 1) begin errors++; $display("FAIL ignore_start_done: got %0d strobes want 1", done_n); end
    endtask

    task automatic test_reset_mid();
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({busy, en_count, sum} !== {2'b11, 8'hF0}) begin
            errors++;
            $display("FAIL mid_shift_state: got busy=%b en=%b sum=%h want 1 1 f0", busy, en_count, sum);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({sum, cout, busy, done, err, en_count, cnt_clr} !== {8'h00, 6'b000001}) begin
            errors++;
            $display("FAIL reset_mid_outputs: got sum=%h cout=%b busy=%b done=%b err=%b en=%b clr=%b", sum, cout, busy, done, err, en_count, cnt_clr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_add(8'h12, 8'h34, 1'b0, 0);
        checks++;
        if ({cout, sum} !== 9'h046 || done_n !== 1) begin
            errors++;
            $display("FAIL after_reset_add: got cout=%b sum=%h done=%0d want 0 46 1", cout, sum, done_n);
        end
    endtask

    task automatic test_stub_err();
        do_add(8'hFF, 8'h01, 1'b0, 0);
        stub_mode = 1'b1;
        do_add(8'h10, 8'h20, 1'b0, 0);
        checks++;
        if (done_n !== 0) begin errors++; $display("FAIL stub_done: got %0d strobes want 0", done_n); end
        checks++;
        if (en_n !== WIDTH) begin errors++; $display("FAIL stub_en_count: got %0d want %0d", en_n, WIDTH); end
        checks++;
        if ({err, cout, busy} !== 3'b110) begin errors++; $display("FAIL stub_err: got err=%b cout=%b busy=%b want 1 1 0", err, cout, busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        stub_mode = 1'b0;
        do_add(8'h10, 8'h20, 1'b0, 0);
        checks++;
        if ({err, cout, sum} !== {2'b00, 8'h30} || done_n !== 1) begin
            errors++;
            $display("FAIL err_clear: got err=%b cout=%b sum=%h done=%0d want 0 0 30 1", err, cout, sum, done_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta, tbv;
        logic [8:0] exp_v;
        logic       prevd;
        int         prev, n;
        ta = 8'($urandom); tbv = 8'($urandom);
        exp_v = 9'(ta) + 9'(tbv);
        a = ta; b = tbv; cin = 1'b0; start = 1'b1;
        prevd = 1'b0; prev = -1; n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                n++;
                checks++;
                if ({cout, sum} !== exp_v || prevd !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result: got %b_%h prev_done=%b want %h prev_done=0", cout, sum, prevd, exp_v);
                end
                if (prev >= 0) begin
                    checks++;
                    if (k - prev !== WIDTH + 4) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", k - prev, WIDTH + 4); end
                end
                prev = k;
            end
            prevd = done;
        end
        start = 1'b0;
        checks++;
        if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d strobes want 3", n); end
        repeat (14) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_stub_err();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
